// File: rtl/adc_serial_reader_if.sv
// adc_serial_reader_if: bundles the conversion handshake (start / sample /
// sample_valid / busy) and the ADC serial pins into one port.
// The slave modport is the reader itself; the master modport is whatever
// requests conversions and sits on the ADC side of the serial pins.
// Optional overrun status (ADC_OVERRUN_EN) adds overrun and overrun_count.
interface adc_serial_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 start;
  logic                 adc_sdata;
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 busy;
`ifdef ADC_OVERRUN_EN
  logic                 overrun;
  logic [7:0]           overrun_count;
`endif

  modport master (
    output start, adc_sdata,
    input  adc_cs_n, adc_sclk, sample, sample_valid, busy
`ifdef ADC_OVERRUN_EN
    , input overrun, overrun_count
`endif
  );

  modport slave (
    input  start, adc_sdata,
    output adc_cs_n, adc_sclk, sample, sample_valid, busy
`ifdef ADC_OVERRUN_EN
    , output overrun, overrun_count
`endif
  );
endinterface

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: on each accepted start pulse, runs one serial read frame
// against an SPI-style ADC (chip select low, FRAME_BITS sclk periods, data
// sampled MSB first on each sclk rising edge) and presents the low DATA_BITS
// of the frame as a registered sample with a one-cycle valid strobe.
// After a frame, chip select stays high for QUIET_CYCLES before the next
// start is accepted; starts arriving while busy are dropped.
// Optional feature macro: ADC_OVERRUN_EN adds overrun / overrun_count status
// for starts that arrive while busy.
module adc_serial_reader #(
  parameter int DATA_BITS    = 12,
  parameter int FRAME_BITS   = 16,
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  adc_serial_reader_if.slave bus
);

  localparam int DIV_W   = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
  localparam int BIT_W   = (FRAME_BITS > 1)   ? $clog2(FRAME_BITS)   : 1;
  localparam int QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [QUIET_W-1:0]    quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;

  // State, counters and every output are registered; reset parks the ADC
  // interface (cs_n and sclk high) immediately, even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shift_q     <= '0;
      sample_q    <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  // Frame sequencer: next state plus the next value of every registered output.
  // sclk phases are timed by div_cnt; the low->high sclk transition is the
  // edge that captures adc_sdata, so the ADC has a full low phase to settle.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shift_d     = shift_q;
    sample_d    = sample_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d   = SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          div_cnt_d = '0;
        end
      end

      SETUP: begin
        if (div_cnt_q == DIV_LAST) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1) | FRAME_BITS'(bus.adc_sdata);
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d     = QUIET;
            cs_n_d      = 1'b1;
            sample_d    = shift_q[DATA_BITS-1:0];
            valid_d     = 1'b1;
            quiet_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sclk_d    = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      QUIET: begin
        if (quiet_cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;

`ifdef ADC_OVERRUN_EN
  logic       overrun_q, overrun_d;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  // A start seen while busy is dropped but flagged; the count saturates.
  always_comb begin
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt_q;
    if (bus.start && busy_q) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != 8'hFF) begin
        overrun_cnt_d = overrun_cnt_q + 8'd1;
      end
    end
  end

  // Overrun status registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 8'd0;
    end else begin
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign bus.overrun       = overrun_q;
  assign bus.overrun_count = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: scoreboard bench for adc_serial_reader.
// dut_a uses the default parameters; dut_b uses CLK_DIV=1, 8-bit frames.
// Stimulus pushes expected samples (value and arrival cycle) into queues;
// independent monitors pop and compare whenever sample_valid is seen.
// With ADC_OVERRUN_EN defined the overrun counter is also checked.
module tb_adc_serial_reader;

  typedef struct {
    logic [11:0] data;
    int          cycle;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   passed  = 0;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [15:0] frame_q_a[$];
  logic [7:0]  frame_q_b[$];
  logic [15:0] cur_frame_a = '0;
  logic [7:0]  cur_frame_b = '0;
  int          bit_idx_a   = -1;
  int          bit_idx_b   = -1;
  int          sclk_rise_a = 0;
  int          sclk_rise_b = 0;
  int          sclk_idle_toggle = 0;
  int          hold_bad_a  = 0;
  logic [11:0] last_sample_a = '0;

  adc_serial_reader_if #(.DATA_BITS(12)) bus_a ();
  adc_serial_reader_if #(.DATA_BITS(8))  bus_b ();

  adc_serial_reader #(
    .DATA_BITS(12), .FRAME_BITS(16), .CLK_DIV(4), .QUIET_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );

  adc_serial_reader #(
    .DATA_BITS(8), .FRAME_BITS(8), .CLK_DIV(1), .QUIET_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  // ADC model A: load the next queued frame when chip select falls
  always @(negedge bus_a.adc_cs_n) begin
    cur_frame_a = (frame_q_a.size() > 0) ? frame_q_a.pop_front() : 16'h0000;
    bit_idx_a   = 15;
  end

  // ADC model A: present the next bit, MSB first, on each falling sclk
  always @(negedge bus_a.adc_sclk) begin
    if (bit_idx_a >= 0) begin
      bus_a.adc_sdata = cur_frame_a[bit_idx_a];
      bit_idx_a--;
    end
  end

  // ADC model B: load the next queued frame when chip select falls
  always @(negedge bus_b.adc_cs_n) begin
    cur_frame_b = (frame_q_b.size() > 0) ? frame_q_b.pop_front() : 8'h00;
    bit_idx_b   = 7;
  end

  // ADC model B: present the next bit, MSB first, on each falling sclk
  always @(negedge bus_b.adc_sclk) begin
    if (bit_idx_b >= 0) begin
      bus_b.adc_sdata = cur_frame_b[bit_idx_b];
      bit_idx_b--;
    end
  end

  // Count sclk rising edges that belong to a frame (chip select low)
  always @(posedge bus_a.adc_sclk) if (!bus_a.adc_cs_n) sclk_rise_a++;
  always @(posedge bus_b.adc_sclk) if (!bus_b.adc_cs_n) sclk_rise_b++;

  // sclk must never move while chip select is high outside reset
  always @(bus_a.adc_sclk) if (rst_n_a && bus_a.adc_cs_n) sclk_idle_toggle++;
  always @(bus_b.adc_sclk) if (rst_n_b && bus_b.adc_cs_n) sclk_idle_toggle++;

  // Monitor A: compare each strobe against the scoreboard, track sample hold
  always @(negedge clk) begin
    exp_t e;
    if (rst_n_a && bus_a.sample_valid) begin
      if (exp_a.size() == 0) begin
        check_output("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_a.pop_front();
        check_output("a_sample", 32'(bus_a.sample), 32'(e.data));
        check_output("a_valid_cycle", cyc, e.cycle);
        check_output("a_cs_n_at_valid", 32'(bus_a.adc_cs_n), 32'd1);
        check_output("a_sclk_rises", sclk_rise_a, 32'd16);
      end
      sclk_rise_a = 0;
    end else if (rst_n_a && bus_a.sample !== last_sample_a) begin
      hold_bad_a++;
    end
    last_sample_a = bus_a.sample;
  end

  // Monitor B: compare each strobe against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n_b && bus_b.sample_valid) begin
      if (exp_b.size() == 0) begin
        check_output("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_b.pop_front();
        check_output("b_sample", 32'(bus_b.sample), 32'(e.data));
        check_output("b_valid_cycle", cyc, e.cycle);
        check_output("b_sclk_rises", sclk_rise_b, 32'd8);
      end
      sclk_rise_b = 0;
    end
  end

  // One start pulse on A; optionally schedule the expected sample
  task automatic apply_stimulus(input logic [15:0] frame, input bit expect_it,
                                output int start_cyc);
    exp_t e;
    @(negedge clk);
    start_cyc = cyc;
    frame_q_a.push_back(frame);
    if (expect_it) begin
      e.data  = frame[11:0];
      e.cycle = start_cyc + 133;
      exp_a.push_back(e);
    end
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic pulse_start_at(input int target);
    while (cyc < target) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit, input string name);
    int n = 0;
    while ((bus_a.busy || exp_a.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.busy || exp_a.size() != 0) check_output(name, 32'd1, 32'd0);
  endtask

  task automatic wait_idle_b(input int limit, input string name);
    int n = 0;
    while ((bus_b.busy || exp_b.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus_b.busy || exp_b.size() != 0) check_output(name, 32'd1, 32'd0);
  endtask

  initial begin
    int   c;
    int   bad;
    exp_t e;
    bus_a.start = 1'b0;
    bus_a.adc_sdata = 1'b0;
    bus_b.start = 1'b0;
    bus_b.adc_sdata = 1'b0;

    // Reset values
    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #1;
    check_output("rst_a_cs_n", 32'(bus_a.adc_cs_n), 32'd1);
    check_output("rst_a_sclk", 32'(bus_a.adc_sclk), 32'd1);
    check_output("rst_a_sample", 32'(bus_a.sample), 32'd0);
    check_output("rst_a_valid", 32'(bus_a.sample_valid), 32'd0);
    check_output("rst_a_busy", 32'(bus_a.busy), 32'd0);
    check_output("rst_b_cs_n", 32'(bus_b.adc_cs_n), 32'd1);
    check_output("rst_b_sclk", 32'(bus_b.adc_sclk), 32'd1);
    check_output("rst_b_sample", 32'(bus_b.sample), 32'd0);
    @(negedge clk);
    #2;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // No start: outputs stay static
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus_a.adc_cs_n !== 1'b1 || bus_a.adc_sclk !== 1'b1 || bus_a.busy !== 1'b0 ||
          bus_a.sample_valid !== 1'b0 || bus_a.sample !== 12'h000 ||
          bus_b.adc_cs_n !== 1'b1 || bus_b.adc_sclk !== 1'b1 || bus_b.busy !== 1'b0)
        bad++;
    end
    check_output("idle_static", bad, 32'd0);

    // Single frame 0x0ABC -> 0xABC at cycle +133
    $display("[TB] single frame");
    apply_stimulus(16'h0ABC, 1'b1, c);
    check_output("busy_after_start", 32'(bus_a.busy), 32'd1);
    check_output("cs_n_after_start", 32'(bus_a.adc_cs_n), 32'd0);
    wait_idle_a(400, "single_timeout");

    // Starts at +10 and +60 while busy are ignored
    $display("[TB] starts while busy");
    apply_stimulus(16'h0123, 1'b1, c);
    pulse_start_at(c + 10);
    pulse_start_at(c + 60);
    wait_idle_a(400, "busy_starts_timeout");
    repeat (20) @(negedge clk);
    check_output("sample_held", 32'(bus_a.sample), 32'h123);
    check_output("no_extra_frame", 32'(bus_a.busy), 32'd0);
`ifdef ADC_OVERRUN_EN
    check_output("overrun_count", 32'(bus_a.overrun_count), 32'd2);
`endif

    // start held high: back-to-back frames 141 cycles apart
    $display("[TB] held start");
    @(negedge clk);
    c = cyc;
    frame_q_a.push_back(16'h0001);
    frame_q_a.push_back(16'h0FFF);
    e.data = 12'h001; e.cycle = c + 133;       exp_a.push_back(e);
    e.data = 12'hFFF; e.cycle = c + 141 + 133; exp_a.push_back(e);
    bus_a.start = 1'b1;
    while (cyc < c + 142) @(negedge clk);
    bus_a.start = 1'b0;
    wait_idle_a(400, "held_timeout");

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    apply_stimulus(16'h0555, 1'b0, c);
    while (cyc < c + 70) @(negedge clk);
    check_output("pre_rst_sclk_low", 32'(bus_a.adc_sclk), 32'd0);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_output("abort_cs_n", 32'(bus_a.adc_cs_n), 32'd1);
    check_output("abort_sclk", 32'(bus_a.adc_sclk), 32'd1);
    check_output("abort_sample", 32'(bus_a.sample), 32'd0);
    check_output("abort_busy", 32'(bus_a.busy), 32'd0);
    @(negedge clk);
    #2;
    rst_n_a = 1'b1;
    sclk_rise_a = 0;
    repeat (150) @(negedge clk);
    apply_stimulus(16'h0DEF, 1'b1, c);
    wait_idle_a(400, "post_reset_timeout");

    // Small configuration: CLK_DIV=1, 8-bit frame 0xA5 at cycle +18
    $display("[TB] small configuration");
    @(negedge clk);
    c = cyc;
    frame_q_b.push_back(8'hA5);
    e.data = 12'h0A5; e.cycle = c + 18; exp_b.push_back(e);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    wait_idle_b(100, "small_timeout");

    repeat (5) @(negedge clk);
    check_output("a_sample_hold", hold_bad_a, 32'd0);
    check_output("sclk_idle_toggle", sclk_idle_toggle, 32'd0);
    check_output("a_queue_empty", exp_a.size(), 32'd0);
    check_output("b_queue_empty", exp_b.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
